// File: rtl/core_inst_seq.sv
// core_inst_seq: produces the 35-bit instruction word that drives the core.
// One word is produced per clock. A tile runs in weight-stationary (WS) or
// output-stationary (OS) order: kernel load, activation load, execute, then
// drain to pmem. Every output is registered, so the word for a state appears
// on inst_o one cycle after the FSM enters that state.
module core_inst_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  mode_in_i,
  input  logic                  acc_en_i,
  input  logic [CNT_W-1:0]      num_t_i,
  input  logic [ADDR_W-1:0]     w_base_i,
  input  logic [ADDR_W-1:0]     x_base_i,
  input  logic [ADDR_W-1:0]     p_base_i,
  input  logic                  ofifo_valid_i,
  output logic [2*ADDR_W+12:0]  inst_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = CNT_W + 2;
  localparam int IW = 2 * ADDR_W + 13;
  localparam logic [IW-1:0] IDLE_WORD =
    {2'b00, 2'b11, {ADDR_W{1'b0}}, 2'b11, {ADDR_W{1'b0}}, 7'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_WLD, S_WFL, S_XLD, S_OLD, S_EXE, S_DRN, S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   outIdx_q, outIdx_d;
  logic [1:0]         phase_q, phase_d;
  logic               mode_q, mode_d;
  logic               acc_q, acc_d;
  logic [CNT_W-1:0]   numT_q, numT_d;
  logic [ADDR_W-1:0]  wBase_q, wBase_d;
  logic [ADDR_W-1:0]  xBase_q, xBase_d;
  logic [ADDR_W-1:0]  pBase_q, pBase_d;
  logic [IW-1:0]      inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accBit, pmemRd, pmemWr, xmemRd;
  logic               ofifoRd, ififoWr, ififoRd, l0Rd, l0Wr, exec, load;
  logic [ADDR_W-1:0]  pAddr, xAddr, pAddrOut, xAddrOut;
  logic [CW-1:0]      tExt, exeLast;
  logic [CNT_W-1:0]   drainLast;

  assign tExt      = CW'(numT_q);
  assign exeLast   = mode_q ? (tExt + CW'(row + col - 1)) : (tExt - CW'(1));
  assign drainLast = mode_q ? CNT_W'(row - 1) : (numT_q - CNT_W'(1));

  // Next-state, counters and the control fields of the next instruction word.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    outIdx_d = outIdx_q;
    phase_d  = phase_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    numT_d   = numT_q;
    wBase_d  = wBase_q;
    xBase_d  = xBase_q;
    pBase_d  = pBase_q;
    accBit   = 1'b0;
    pmemRd   = 1'b0;
    pmemWr   = 1'b0;
    xmemRd   = 1'b0;
    ofifoRd  = 1'b0;
    ififoWr  = 1'b0;
    ififoRd  = 1'b0;
    l0Rd     = 1'b0;
    l0Wr     = 1'b0;
    exec     = 1'b0;
    load     = 1'b0;
    pAddr    = pBase_q + ADDR_W'(outIdx_q);
    xAddr    = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          mode_d   = mode_in_i;
          acc_d    = acc_en_i & ~mode_in_i;
          numT_d   = (num_t_i == '0) ? CNT_W'(1) : num_t_i;
          wBase_d  = w_base_i;
          xBase_d  = x_base_i;
          pBase_d  = p_base_i;
          outIdx_d = '0;
          phase_d  = '0;
          state_d  = mode_in_i ? S_OLD : S_WLD;
        end
      end
      S_WLD: begin
        xmemRd = (cnt_q < CW'(row));
        xAddr  = wBase_q + ADDR_W'(cnt_q);
        l0Wr   = (cnt_q != '0);
        if (cnt_q == CW'(row)) begin
          state_d = S_WFL;
          cnt_d   = '0;
        end
      end
      S_WFL: begin
        l0Rd = 1'b1;
        load = 1'b1;
        if (cnt_q == CW'(row + col - 1)) begin
          state_d = S_XLD;
          cnt_d   = '0;
        end
      end
      S_XLD: begin
        xmemRd = (cnt_q < tExt);
        xAddr  = xBase_q + ADDR_W'(cnt_q);
        l0Wr   = (cnt_q != '0);
        if (cnt_q == tExt) begin
          state_d = S_EXE;
          cnt_d   = '0;
        end
      end
      S_OLD: begin
        xmemRd  = (cnt_q < (tExt << 1));
        xAddr   = (cnt_q[0] ? wBase_q : xBase_q) + ADDR_W'(cnt_q >> 1);
        l0Wr    = (cnt_q != '0) && cnt_q[0];
        ififoWr = (cnt_q != '0) && !cnt_q[0];
        if (cnt_q == (tExt << 1)) begin
          state_d = S_EXE;
          cnt_d   = '0;
        end
      end
      S_EXE: begin
        l0Rd    = 1'b1;
        exec    = 1'b1;
        ififoRd = mode_q && (cnt_q < tExt);
        if (cnt_q == exeLast) begin
          state_d  = S_DRN;
          cnt_d    = '0;
          outIdx_d = '0;
          phase_d  = '0;
        end
      end
      S_DRN: begin
        accBit = acc_q;
        cnt_d  = cnt_q;
        if (acc_q) begin
          case (phase_q)
            2'd0: begin
              if (ofifo_valid_i) begin
                pmemRd  = 1'b1;
                phase_d = 2'd1;
              end
            end
            2'd1: begin
              if (ofifo_valid_i) begin
                ofifoRd = 1'b1;
                phase_d = 2'd2;
              end
            end
            default: begin
              pmemWr   = 1'b1;
              phase_d  = 2'd0;
              outIdx_d = outIdx_q + CNT_W'(1);
              if (outIdx_q == drainLast) state_d = S_FIN;
            end
          endcase
        end else if (phase_q == 2'd0) begin
          if (ofifo_valid_i) begin
            ofifoRd = 1'b1;
            phase_d = 2'd1;
          end
        end else begin
          pmemWr   = 1'b1;
          phase_d  = 2'd0;
          outIdx_d = outIdx_q + CNT_W'(1);
          if (outIdx_q == drainLast) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pack the instruction word. Idle memory ports always present a zero address.
  always_comb begin
    pAddrOut = (pmemRd | pmemWr) ? pAddr : '0;
    xAddrOut = xmemRd ? xAddr : '0;
    inst_d   = {mode_d, accBit, ~(pmemRd | pmemWr), ~pmemWr, pAddrOut,
                ~xmemRd, 1'b1, xAddrOut,
                ofifoRd, ififoWr, ififoRd, l0Rd, l0Wr, exec, load};
    busy_d   = (state_q != S_FIN) && (state_d != S_IDLE);
    done_d   = (state_q == S_FIN);
  end

  // State, latched tile configuration and the registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      outIdx_q <= '0;
      phase_q  <= '0;
      mode_q   <= 1'b0;
      acc_q    <= 1'b0;
      numT_q   <= CNT_W'(1);
      wBase_q  <= '0;
      xBase_q  <= '0;
      pBase_q  <= '0;
      inst_q   <= IDLE_WORD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      outIdx_q <= outIdx_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      numT_q   <= numT_d;
      wBase_q  <= wBase_d;
      xBase_q  <= xBase_d;
      pBase_q  <= pBase_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst_o = inst_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Testbench for core_inst_seq: table-driven tiles plus random tiles, each
// compared word by word against a tile-level reference of the instruction stream.
module tb_core_inst_seq;

  localparam int ROW = 8;
  localparam int COL = 8;

  localparam logic [6:0] C_OFRD = 7'h40;
  localparam logic [6:0] C_IFWR = 7'h20;
  localparam logic [6:0] C_IFRD = 7'h10;
  localparam logic [6:0] C_L0RD = 7'h08;
  localparam logic [6:0] C_L0WR = 7'h04;
  localparam logic [6:0] C_EXE  = 7'h02;
  localparam logic [6:0] C_LOAD = 7'h01;

  typedef struct {
    bit          gated;
    logic [34:0] word;
  } step_t;

  typedef struct {
    bit          mode;
    bit          acc;
    int          t;
    logic [10:0] wb;
    logic [10:0] xb;
    logic [10:0] pb;
    int          stall;
    bit          randValid;
    int          expWr;
    logic [10:0] expLast;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        mode_in_i;
  logic        acc_en_i;
  logic [10:0] num_t_i;
  logic [10:0] w_base_i;
  logic [10:0] x_base_i;
  logic [10:0] p_base_i;
  logic        ofifo_valid_i;
  logic [34:0] inst_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;
  int tileId   = 0;

  always #5 clk_i = ~clk_i;

  core_inst_seq #(.row(ROW), .col(COL), .ADDR_W(11), .CNT_W(11)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_in_i(mode_in_i),
    .acc_en_i(acc_en_i), .num_t_i(num_t_i), .w_base_i(w_base_i),
    .x_base_i(x_base_i), .p_base_i(p_base_i), .ofifo_valid_i(ofifo_valid_i),
    .inst_o(inst_o), .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [34:0] mkWord(input bit m, input bit a, input bit pRd,
                                         input bit pWr, input logic [10:0] pa,
                                         input bit xRd, input logic [10:0] xa,
                                         input logic [6:0] ctl);
    logic [10:0] pOut;
    logic [10:0] xOut;
    pOut = (pRd || pWr) ? pa : 11'd0;
    xOut = xRd ? xa : 11'd0;
    return {m, a, !(pRd || pWr), !pWr, pOut, !xRd, 1'b1, xOut, ctl};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s tile=%0d t=%0t got=%h want=%h", name, tileId, $time, got, want);
    end
  endtask

  // Runs one whole tile, checking every output cycle against the reference stream.
  task automatic applyStimulus(input vec_t v, output int nWr, output logic [10:0] lastWr);
    logic [34:0] pend[$];
    step_t       steps[$];
    step_t       st;
    logic [34:0] expW, idleWord, stallWord;
    logic [10:0] a;
    bit          expBusy, expDone, accE, valid, isAct;
    int          tE, D, n, drainCyc, stage;

    tE   = (v.t == 0) ? 1 : v.t;
    accE = v.acc && !v.mode;
    D    = v.mode ? ROW : tE;

    if (!v.mode) begin
      for (int i = 0; i <= ROW; i++)
        pend.push_back(mkWord(0, 0, 0, 0, 11'd0, i < ROW, v.wb + 11'(i), (i >= 1) ? C_L0WR : 7'h0));
      for (int i = 0; i < ROW + COL; i++)
        pend.push_back(mkWord(0, 0, 0, 0, 11'd0, 0, 11'd0, C_L0RD | C_LOAD));
      for (int i = 0; i <= tE; i++)
        pend.push_back(mkWord(0, 0, 0, 0, 11'd0, i < tE, v.xb + 11'(i), (i >= 1) ? C_L0WR : 7'h0));
      for (int i = 0; i < tE; i++)
        pend.push_back(mkWord(0, 0, 0, 0, 11'd0, 0, 11'd0, C_L0RD | C_EXE));
    end else begin
      for (int s = 0; s <= 2 * tE; s++) begin
        isAct = (s % 2 == 0);
        pend.push_back(mkWord(1, 0, 0, 0, 11'd0, s < 2 * tE, (isAct ? v.xb : v.wb) + 11'(s / 2),
                              (s == 0) ? 7'h0 : (((s - 1) % 2 == 0) ? C_L0WR : C_IFWR)));
      end
      for (int i = 0; i < tE + ROW + COL; i++)
        pend.push_back(mkWord(1, 0, 0, 0, 11'd0, 0, 11'd0, C_L0RD | C_EXE | ((i < tE) ? C_IFRD : 7'h0)));
    end

    for (int k = 0; k < D; k++) begin
      a = v.pb + 11'(k);
      if (accE) begin
        st.gated = 1'b1; st.word = mkWord(v.mode, 1, 1, 0, a, 0, 11'd0, 7'h0);   steps.push_back(st);
        st.gated = 1'b1; st.word = mkWord(v.mode, 1, 0, 0, 11'd0, 0, 11'd0, C_OFRD); steps.push_back(st);
        st.gated = 1'b0; st.word = mkWord(v.mode, 1, 0, 1, a, 0, 11'd0, 7'h0);   steps.push_back(st);
      end else begin
        st.gated = 1'b1; st.word = mkWord(v.mode, 0, 0, 0, 11'd0, 0, 11'd0, C_OFRD); steps.push_back(st);
        st.gated = 1'b0; st.word = mkWord(v.mode, 0, 0, 1, a, 0, 11'd0, 7'h0);   steps.push_back(st);
      end
    end
    stallWord = mkWord(v.mode, accE, 0, 0, 11'd0, 0, 11'd0, 7'h0);
    idleWord  = mkWord(v.mode, 0, 0, 0, 11'd0, 0, 11'd0, 7'h0);

    start_i       = 1'b1;
    mode_in_i     = v.mode;
    acc_en_i      = v.acc;
    num_t_i       = 11'(v.t);
    w_base_i      = v.wb;
    x_base_i      = v.xb;
    p_base_i      = v.pb;
    ofifo_valid_i = 1'b0;
    tick();
    start_i = 1'b0;

    expW = idleWord; expBusy = 1'b1; expDone = 1'b0;
    nWr = 0; lastWr = 11'd0; n = 0; drainCyc = 0; stage = 0;
    while (1) begin
      checkOutput("inst", 64'(inst_o), 64'(expW));
      checkOutput("busy", 64'(busy_o), 64'(expBusy));
      checkOutput("done", 64'(done_o), 64'(expDone));
      if (inst_o[32] == 1'b0 && inst_o[31] == 1'b0) begin
        nWr++;
        lastWr = inst_o[30:20];
      end
      if (stage == 2) break;
      // Configuration inputs are scrambled while busy; a stray start is pulsed once.
      start_i   = (n == 4);
      mode_in_i = 1'($urandom);
      acc_en_i  = 1'($urandom);
      num_t_i   = 11'($urandom);
      w_base_i  = 11'($urandom);
      x_base_i  = 11'($urandom);
      p_base_i  = 11'($urandom);
      if (stage == 1) begin
        ofifo_valid_i = 1'b0;
        expW = idleWord; expBusy = 1'b0; expDone = 1'b0; stage = 2;
      end else if (pend.size() != 0) begin
        ofifo_valid_i = 1'($urandom);
        expW = pend.pop_front();
      end else begin
        valid = (drainCyc < v.stall) ? 1'b0 : (v.randValid ? ($urandom_range(0, 3) != 0) : 1'b1);
        ofifo_valid_i = valid;
        drainCyc++;
        if (steps.size() != 0) begin
          if (steps[0].gated && !valid) expW = stallWord;
          else begin
            expW = steps[0].word;
            steps.delete(0);
          end
        end else begin
          expW = idleWord; expBusy = 1'b0; expDone = 1'b1; stage = 1;
        end
      end
      n++;
      if (n > 6000) begin
        checks++;
        failures++;
        $display("[TB] FAIL tile_timeout tile=%0d got=running want=finished", tileId);
        break;
      end
      tick();
    end
    start_i       = 1'b0;
    ofifo_valid_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        tbl[7];
    vec_t        rv;
    int          nWr;
    logic [10:0] lastWr;
    logic [34:0] idle0;

    idle0 = mkWord(0, 0, 0, 0, 11'd0, 0, 11'd0, 7'h0);
    tbl[0] = '{mode:0, acc:0, t:4, wb:11'd0,  xb:11'd8,    pb:11'd16,   stall:0,  randValid:0, expWr:4, expLast:11'd19};
    tbl[1] = '{mode:0, acc:1, t:2, wb:11'd0,  xb:11'd8,    pb:11'd16,   stall:0,  randValid:0, expWr:2, expLast:11'd17};
    tbl[2] = '{mode:1, acc:1, t:3, wb:11'd40, xb:11'd32,   pb:11'd100,  stall:0,  randValid:0, expWr:8, expLast:11'd107};
    tbl[3] = '{mode:0, acc:0, t:3, wb:11'd5,  xb:11'd300,  pb:11'd50,   stall:10, randValid:0, expWr:3, expLast:11'd52};
    tbl[4] = '{mode:0, acc:0, t:4, wb:11'd1,  xb:11'd2045, pb:11'd2046, stall:0,  randValid:0, expWr:4, expLast:11'd1};
    tbl[5] = '{mode:1, acc:0, t:1, wb:11'd9,  xb:11'd2047, pb:11'd2044, stall:3,  randValid:1, expWr:8, expLast:11'd3};
    tbl[6] = '{mode:0, acc:1, t:0, wb:11'd70, xb:11'd90,   pb:11'd7,    stall:2,  randValid:1, expWr:1, expLast:11'd7};

    rst_ni = 1'b0; start_i = 1'b0; mode_in_i = 1'b0; acc_en_i = 1'b0; num_t_i = 11'd0;
    w_base_i = 11'd0; x_base_i = 11'd0; p_base_i = 11'd0; ofifo_valid_i = 1'b0;
    #12;
    checkOutput("reset_inst", 64'(inst_o), 64'(idle0));
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_done", 64'(done_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Asynchronous reset in the middle of the weight load.
    start_i = 1'b1; mode_in_i = 1'b0; num_t_i = 11'd4; w_base_i = 11'd0; x_base_i = 11'd8; p_base_i = 11'd16;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("midWld_read", 64'(inst_o[19]), 64'd0);
    #3 rst_ni = 1'b0;
    #1;
    checkOutput("midReset_inst", 64'(inst_o), 64'(idle0));
    checkOutput("midReset_busy", 64'(busy_o), 64'd0);
    checkOutput("midReset_done", 64'(done_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    checkOutput("postReset_inst", 64'(inst_o), 64'(idle0));

    for (int i = 0; i < 7; i++) begin
      tileId = i;
      applyStimulus(tbl[i], nWr, lastWr);
      checkOutput("pmem_writes", 64'(nWr), 64'(tbl[i].expWr));
      checkOutput("last_write_addr", 64'(lastWr), 64'(tbl[i].expLast));
    end

    for (int r = 0; r < 6; r++) begin
      tileId       = 100 + r;
      rv.mode      = 1'($urandom);
      rv.acc       = 1'($urandom);
      rv.t         = $urandom_range(1, 12);
      rv.wb        = 11'($urandom);
      rv.xb        = 11'($urandom);
      rv.pb        = 11'($urandom);
      rv.stall     = $urandom_range(0, 5);
      rv.randValid = 1'b1;
      rv.expWr     = rv.mode ? ROW : rv.t;
      rv.expLast   = rv.pb + 11'(rv.expWr - 1);
      applyStimulus(rv, nWr, lastWr);
      checkOutput("pmem_writes", 64'(nWr), 64'(rv.expWr));
      checkOutput("last_write_addr", 64'(lastWr), 64'(rv.expLast));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
